qam16_symbol_upsampler: RTL and testbench

Upstream neighbour of the 11-tap RRC pulse-shaping filter in the QAM16 transmit chain.
- Accepts payload bytes over a valid/ready handshake.
- Splits each byte into two 4-bit symbols and Gray-maps each symbol to signed 4-bit I and Q levels (-3, -1, +1, +3).
- Zero-stuffs to SPS samples per symbol, producing the signed 4-bit sample stream the I and Q RRC filters consume.

---
 rtl/qam16_pkg.sv | 46 ++++
 rtl/qam16_nibble_map.sv | 19 +
 rtl/qam16_symbol_upsampler.sv | 133 +++++++++++++
 tb/tb_qam16_symbol_upsampler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// QAM16 shared definitions: symbol width, Gray-coded level constants and the
// 2-bit Gray code <-> level helpers. Used by the symbol upsampler, the RRC
// filters and the receive slicer.
package qam16_pkg;

   localparam int SYM_W = 4;

   typedef logic signed [SYM_W-1:0] level_t;

   localparam level_t LVL_M3 = -4'sd3;
   localparam level_t LVL_M1 = -4'sd1;
   localparam level_t LVL_P1 = 4'sd1;
   localparam level_t LVL_P3 = 4'sd3;

   // Gray order along the axis: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3,
   // so neighbouring levels differ in exactly one bit.
   function automatic level_t gray_to_level(input logic [1:0] code);
      level_t lvl;
      lvl = LVL_M3;
      case (code)
         2'b00:   lvl = LVL_M3;
         2'b01:   lvl = LVL_M1;
         2'b11:   lvl = LVL_P1;
         2'b10:   lvl = LVL_P3;
         default: lvl = LVL_M3;
      endcase
      return lvl;
   endfunction

   // Hard decision back to the Gray code; thresholds sit halfway between
   // levels (-2, 0, +2) so the slicer can feed filtered samples directly.
   function automatic logic [1:0] level_to_gray(input level_t lvl);
      logic [1:0] code;
      if (lvl < -4'sd2) begin
         code = 2'b00;
      end else if (lvl < 4'sd0) begin
         code = 2'b01;
      end else if (lvl < 4'sd2) begin
         code = 2'b11;
      end else begin
         code = 2'b10;
      end
      return code;
   endfunction

endpackage

// File: rtl/qam16_nibble_map.sv
// QAM16 nibble mapper (combinational).
// Ports:
//   nibble  in  4  symbol bits b3b2b1b0
//   level_i out 4  signed I level from b3b2
//   level_q out 4  signed Q level from b1b0
module qam16_nibble_map
   import qam16_pkg::*;
(
   input  logic [3:0] nibble,
   output level_t     level_i,
   output level_t     level_q
);

   always_comb begin
      level_i = gray_to_level(nibble[3:2]);
      level_q = gray_to_level(nibble[1:0]);
   end

endmodule

// File: rtl/qam16_symbol_upsampler.sv
// QAM16 symbol upsampler: takes payload bytes over valid/ready, splits each
// into two nibbles, Gray-maps them to signed I/Q levels and zero-stuffs to
// SPS samples per symbol for the I/Q RRC filters.
//
// State registers:
//   reg       | meaning
//   byte_buf  | payload byte waiting to be emitted
//   buf_valid | byte_buf holds at least one unsent nibble
//   nib       | 0: first nibble of byte_buf is next, 1: second nibble is next
//   phase     | sample index within the current symbol period (0..SPS-1)
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-low reset
//   in_data    in   8  payload byte
//   in_valid   in   1  in_data valid
//   in_ready   out  1  a byte can be accepted this cycle
//   sample_en  in   1  advance one output sample; low freezes all state
//   out_i      out  4  signed I sample
//   out_q      out  4  signed Q sample
//   out_valid  out  1  sample belongs to a real symbol period
//   sym_strobe out  1  out_i/out_q carry a new symbol
//   underrun   out  1  a symbol was due and no byte was buffered
module qam16_symbol_upsampler
   import qam16_pkg::*;
#(
   parameter int SPS       = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       sample_en,
   output level_t     out_i,
   output level_t     out_q,
   output logic       out_valid,
   output logic       sym_strobe,
   output logic       underrun
);

   localparam int PH_W = $clog2(SPS);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

   logic [7:0]      byte_buf;
   logic            buf_valid;
   logic            buf_valid_next;
   logic            nib;
   logic [PH_W-1:0] phase;

   logic            accept;
   logic            emit;
   logic            consume;
   logic            first_half;
   logic [3:0]      sel_nibble;
   level_t          map_i;
   level_t          map_q;

   assign accept  = in_valid && in_ready;
   assign emit    = sample_en && (phase == '0) && buf_valid;
   assign consume = emit && nib;

   // nib=0 picks the half that goes out first; MSB_FIRST decides which half.
   assign first_half = (nib == 1'b0);
   assign sel_nibble = (first_half == MSB_FIRST) ? byte_buf[7:4] : byte_buf[3:0];

   // in_ready is only high while the buffer is empty, so accept and consume
   // never coincide and the refill lands one edge after the last emit.
   always_comb begin
      buf_valid_next = buf_valid;
      if (accept) begin
         buf_valid_next = 1'b1;
      end else if (consume) begin
         buf_valid_next = 1'b0;
      end
   end

   qam16_nibble_map u_map (
      .nibble  (sel_nibble),
      .level_i (map_i),
      .level_q (map_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_buf   <= '0;
         buf_valid  <= 1'b0;
         nib        <= 1'b0;
         phase      <= '0;
         in_ready   <= 1'b0;
         out_i      <= '0;
         out_q      <= '0;
         out_valid  <= 1'b0;
         sym_strobe <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         buf_valid  <= buf_valid_next;
         in_ready   <= !buf_valid_next;
         sym_strobe <= 1'b0;
         underrun   <= 1'b0;
         if (accept) begin
            byte_buf <= in_data;
         end
         if (sample_en) begin
            if (phase == '0) begin
               if (buf_valid) begin
                  out_i      <= map_i;
                  out_q      <= map_q;
                  out_valid  <= 1'b1;
                  sym_strobe <= 1'b1;
                  phase      <= PH_ONE;
                  nib        <= !nib;
               end else begin
                  // Symbol slot with nothing to send: stay at phase 0 and
                  // retry on every enabled cycle.
                  out_i     <= '0;
                  out_q     <= '0;
                  out_valid <= 1'b0;
                  underrun  <= 1'b1;
               end
            end else begin
               out_i     <= '0;
               out_q     <= '0;
               out_valid <= 1'b1;
               phase     <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_qam16_symbol_upsampler.sv
// Testbench for qam16_symbol_upsampler: three instances (SPS=4 MSB first,
// SPS=4 LSB first, SPS=2 MSB first) share stimulus; one is selected for
// checking at a time. Expected samples are queued by the stimulus and
// compared by an independent monitor on every enabled edge.
module tb_qam16_symbol_upsampler;

   typedef struct packed {
      logic [3:0] i;
      logic [3:0] q;
      logic       v;
      logic       s;
      logic       u;
   } smp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       sample_en;
   logic [1:0] sel;

   logic       rdy [3];
   logic [3:0] oi  [3];
   logic [3:0] oq  [3];
   logic       ov  [3];
   logic       ss  [3];
   logic       ur  [3];

   logic       m_rdy;
   logic [3:0] m_i;
   logic [3:0] m_q;
   logic       m_v;
   logic       m_s;
   logic       m_u;

   int checks = 0;
   int errors = 0;

   smp_t exp_q[$];

   int ti [16] = '{-3, -3, -3, -3, -1, -1, -1, -1, 3, 3, 3, 3, 1, 1, 1, 1};
   int tq [16] = '{-3, -1, 3, 1, -3, -1, 3, 1, -3, -1, 3, 1, -3, -1, 3, 1};

   always #5 clk = ~clk;

   qam16_symbol_upsampler #(.SPS(4), .MSB_FIRST(1'b1)) u_s4_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[0]), .sample_en(sample_en), .out_i(oi[0]), .out_q(oq[0]),
      .out_valid(ov[0]), .sym_strobe(ss[0]), .underrun(ur[0])
   );

   qam16_symbol_upsampler #(.SPS(4), .MSB_FIRST(1'b0)) u_s4_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[1]), .sample_en(sample_en), .out_i(oi[1]), .out_q(oq[1]),
      .out_valid(ov[1]), .sym_strobe(ss[1]), .underrun(ur[1])
   );

   qam16_symbol_upsampler #(.SPS(2), .MSB_FIRST(1'b1)) u_s2_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[2]), .sample_en(sample_en), .out_i(oi[2]), .out_q(oq[2]),
      .out_valid(ov[2]), .sym_strobe(ss[2]), .underrun(ur[2])
   );

   always_comb begin
      m_rdy = rdy[0]; m_i = oi[0]; m_q = oq[0]; m_v = ov[0]; m_s = ss[0]; m_u = ur[0];
      case (sel)
         2'd1: begin
            m_rdy = rdy[1]; m_i = oi[1]; m_q = oq[1]; m_v = ov[1]; m_s = ss[1]; m_u = ur[1];
         end
         2'd2: begin
            m_rdy = rdy[2]; m_i = oi[2]; m_q = oq[2]; m_v = ov[2]; m_s = ss[2]; m_u = ur[2];
         end
         default: ;
      endcase
   end

   function automatic smp_t mk(input int i, input int q, input bit v, input bit s, input bit u);
      smp_t r;
      r.i = 4'(i);
      r.q = 4'(q);
      r.v = v;
      r.s = s;
      r.u = u;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_sym(input int i, input int q, input int sps);
      exp_q.push_back(mk(i, q, 1'b1, 1'b1, 1'b0));
      for (int k = 0; k < sps - 1; k++) exp_q.push_back(mk(0, 0, 1'b1, 1'b0, 1'b0));
   endtask

   task automatic push_under(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic drain_check(input string name);
      chk({name, "_leftover_samples"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Starts and ends on a falling edge; returns once the byte on in_data has
   // been taken by an edge with in_ready high.
   task automatic wait_accept(input string name);
      bit r;
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         r = m_rdy;
         @(posedge clk);
         @(negedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_accepted"}, int'(ok), 1);
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      sample_en = 1'b0;
      #1;
      chk("reset_outputs_async", int'({m_rdy, m_i, m_q, m_v, m_s, m_u}), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_release", int'(m_rdy), 1);
      @(negedge clk);
   endtask

   task automatic load_byte(input logic [7:0] b, input string name);
      in_data  = b;
      in_valid = 1'b1;
      wait_accept(name);
      in_valid = 1'b0;
   endtask

   task automatic run_en(input int n);
      for (int k = 0; k < n; k++) begin
         sample_en = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      sample_en = 1'b0;
   endtask

   // Monitor: every enabled edge must match the next queued sample; every
   // disabled edge must hold the data outputs and keep the pulses low.
   initial begin
      smp_t cur;
      smp_t prev;
      smp_t e;
      smp_t held;
      bit   en_e;
      bit   rst_e;
      prev = '0;
      forever begin
         @(posedge clk);
         en_e  = sample_en;
         rst_e = rst;
         #1;
         cur = {m_i, m_q, m_v, m_s, m_u};
         if (rst_e) begin
            checks++;
            if (en_e) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sample_unexpected actual i=%0d q=%0d v=%0d s=%0d u=%0d",
                           $signed(cur.i), $signed(cur.q), cur.v, cur.s, cur.u);
               end else begin
                  e = exp_q.pop_front();
                  if (cur !== e) begin
                     errors++;
                     $display("FAIL sample actual i=%0d q=%0d v=%0d s=%0d u=%0d required i=%0d q=%0d v=%0d s=%0d u=%0d",
                              $signed(cur.i), $signed(cur.q), cur.v, cur.s, cur.u,
                              $signed(e.i), $signed(e.q), e.v, e.s, e.u);
                  end
               end
            end else begin
               held = {prev.i, prev.q, prev.v, 2'b00};
               if (cur !== held) begin
                  errors++;
                  $display("FAIL disabled_hold actual i=%0d q=%0d v=%0d s=%0d u=%0d required i=%0d q=%0d v=%0d s=0 u=0",
                           $signed(cur.i), $signed(cur.q), cur.v, cur.s, cur.u,
                           $signed(prev.i), $signed(prev.q), prev.v);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      rst       = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      sample_en = 1'b0;
      sel       = 2'd0;
      @(negedge clk);

      // Case 1: single byte 0x1E, MSB nibble first, then underruns.
      sel = 2'd0;
      do_reset();
      load_byte(8'h1E, "c1_load");
      push_sym(-3, -1, 4);
      push_sym(1, 3, 4);
      push_under(3);
      run_en(11);
      drain_check("c1");

      // Case 2: LSB nibble first.
      sel = 2'd1;
      do_reset();
      load_byte(8'h1E, "c2_load");
      push_sym(1, 3, 4);
      push_sym(-3, -1, 4);
      push_under(3);
      run_en(11);
      drain_check("c2");

      // Case 3: back-to-back 0x1E, 0xB4 with in_valid held high.
      sel = 2'd0;
      do_reset();
      push_sym(-3, -1, 4);
      push_sym(1, 3, 4);
      push_sym(3, 1, 4);
      push_sym(-1, -3, 4);
      push_under(1);
      in_data  = 8'h1E;
      in_valid = 1'b1;
      wait_accept("c3_first");
      in_data = 8'hB4;
      fork
         begin
            wait_accept("c3_second");
            in_valid = 1'b0;
         end
         begin
            for (int n = 0; n < 17; n++) begin
               sample_en = 1'b1;
               @(posedge clk);
               #1;
               chk($sformatf("c3_in_ready_%0d", n), int'(m_rdy), int'(n == 4 || n >= 12));
               @(negedge clk);
            end
            sample_en = 1'b0;
         end
      join
      drain_check("c3");

      // Case 4: sample_en toggling 1,0,1,0 over the 0x1E frame.
      sel = 2'd0;
      do_reset();
      load_byte(8'h1E, "c4_load");
      push_sym(-3, -1, 4);
      push_sym(1, 3, 4);
      push_under(3);
      for (int n = 0; n < 22; n++) begin
         sample_en = (n % 2 == 0);
         @(posedge clk);
         @(negedge clk);
      end
      sample_en = 1'b0;
      drain_check("c4");

      // Case 5: reset at phase 2 of the first symbol discards the byte.
      sel = 2'd0;
      do_reset();
      load_byte(8'h1E, "c5_load");
      exp_q.push_back(mk(-3, -1, 1'b1, 1'b1, 1'b0));
      exp_q.push_back(mk(0, 0, 1'b1, 1'b0, 1'b0));
      run_en(2);
      chk("c5_out_valid_before_reset", int'(m_v), 1);
      drain_check("c5_pre");
      do_reset();
      push_under(4);
      run_en(4);
      drain_check("c5_post");

      // Case 6: SPS=2, all 16 nibble values in order via bytes 0x01..0xEF.
      sel = 2'd2;
      do_reset();
      for (int n = 0; n < 16; n++) push_sym(ti[n], tq[n], 2);
      push_under(1);
      in_data  = 8'h01;
      in_valid = 1'b1;
      wait_accept("c6_byte0");
      fork
         begin
            for (int k = 1; k < 8; k++) begin
               logic [3:0] hi;
               logic [3:0] lo;
               hi      = 4'(2 * k);
               lo      = 4'(2 * k + 1);
               in_data = {hi, lo};
               wait_accept($sformatf("c6_byte%0d", k));
            end
            in_valid = 1'b0;
         end
         run_en(33);
      join
      drain_check("c6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
